// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows the shared EX-stage ALU.
// Idle/done cycles pass the pipeline's ALU request straight through.
module alu_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  input  logic [3:0]       ex_aluctrl_i,
  input  logic [WIDTH-1:0] ex_src1_i,
  input  logic [WIDTH-1:0] ex_src2_i,
  output logic [3:0]       alu_ctrl_o,
  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             carry;

  // A wrapped sum is smaller than either addend.
  assign carry = alu_result_i < hi_q;

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mc_d       = mc_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    alu_ctrl_o = ex_aluctrl_i;
    alu_src1_o = ex_src1_i;
    alu_src2_o = ex_src2_i;
    stall_o    = 1'b0;
    unique case (state_q)
      S_RUN: begin
        alu_ctrl_o = ALU_ADD;
        alu_src1_o = hi_q;
        alu_src2_o = mc_q;
        stall_o    = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (lo_q[0]) begin
          hi_d = {carry, alu_result_i[WIDTH-1:1]};
          lo_d = {alu_result_i[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_IDLE, S_DONE: begin
        stall_o = start_i;
        state_d = S_IDLE;
        if (start_i) begin
          mc_d    = mcand_i;
          hi_d    = '0;
          lo_d    = mplier_i;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mc_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mc_q    <= mc_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: vector tables, corner sequences,
// and random multiplies against a plain-arithmetic product model.
module tb_alu_mul_sequencer;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [W-1:0]  mcand_i, mplier_i;
  logic [3:0]    ex_aluctrl_i;
  logic [W-1:0]  ex_src1_i, ex_src2_i;
  logic [3:0]    alu_ctrl_o;
  logic [W-1:0]  alu_src1_o, alu_src2_o;
  logic [W-1:0]  alu_result_i;
  logic          stall_o, busy_o, done_o;
  logic [W-1:0]  hi_o, lo_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .mcand_i(mcand_i), .mplier_i(mplier_i),
    .ex_aluctrl_i(ex_aluctrl_i),
    .ex_src1_i(ex_src1_i), .ex_src2_i(ex_src2_i),
    .alu_ctrl_o(alu_ctrl_o),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_result_i(alu_result_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  // Shared ALU model
  always_comb begin
    alu_result_i = '0;
    case (alu_ctrl_o)
      4'b0010: alu_result_i = alu_src1_o + alu_src2_o;
      4'b0110: alu_result_i = alu_src1_o - alu_src2_o;
      4'b0001: alu_result_i = alu_src1_o & alu_src2_o;
      4'b0000: alu_result_i = alu_src1_o | alu_src2_o;
      4'b1101: alu_result_i = ~(alu_src1_o | alu_src2_o);
      4'b0111: alu_result_i = W'($signed(alu_src1_o) < $signed(alu_src2_o));
      default: alu_result_i = '0;
    endcase
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a multiply, runs to the done cycle and returns inside it.
  // start_i is re-raised for RUN cycles h0..h1 to show it is ignored.
  task automatic mul(input string nm, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [63:0] exp,
                     input int h0, input int h1);
    int k, st, bad;
    mcand_i  = a;
    mplier_i = b;
    start_i  = 1'b1;
    #1;
    check({nm, " stall@start"}, 64'(stall_o), 64'd1);
    st = 1;
    bad = 0;
    step();
    start_i  = 1'b0;
    mcand_i  = $urandom;
    mplier_i = $urandom;
    k = 0;
    while (!done_o && k < 3 * W) begin
      start_i = (k >= h0 && k <= h1);
      #1;
      if (stall_o) st++;
      if (alu_ctrl_o !== 4'b0010 || busy_o !== 1'b1) bad++;
      step();
      k++;
    end
    start_i = 1'b0;
    check({nm, " latency"}, 64'(k), 64'(W));
    check({nm, " stall cycles"}, 64'(st), 64'(W + 1));
    check({nm, " run ctrl/busy"}, 64'(bad), 64'd0);
    check({nm, " product"}, {hi_o, lo_o}, exp);
    t_done = cyc;
  endtask

  typedef struct {
    string        nm;
    logic [W-1:0] a, b;
    logic [63:0]  p;
  } mvec_t;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] s1, s2;
    logic [3:0]   e_ctrl;
    logic [W-1:0] e_s1, e_s2;
  } pvec_t;

  mvec_t mv[6];
  pvec_t pv[4];

  initial begin
    int t0, dn;
    logic [W-1:0] ra, rb;

    mv[0] = '{"3x5", 32'd3, 32'd5, 64'd15};
    mv[1] = '{"max x max", 32'hFFFFFFFF, 32'hFFFFFFFF,
              64'hFFFFFFFE_00000001};
    mv[2] = '{"msb x 2", 32'h80000000, 32'd2, 64'h00000001_00000000};
    mv[3] = '{"0 x max", 32'd0, 32'hFFFFFFFF, 64'd0};
    mv[4] = '{"max x 0", 32'hFFFFFFFF, 32'd0, 64'd0};
    mv[5] = '{"1234x5678", 32'd1234, 32'd5678, 64'd7006652};

    pv[0] = '{4'b0110, 32'd9, 32'd4, 4'b0110, 32'd9, 32'd4};
    pv[1] = '{4'b0010, 32'hDEAD, 32'hBEEF, 4'b0010, 32'hDEAD, 32'hBEEF};
    pv[2] = '{4'b1101, 32'hFFFF0000, 32'h1, 4'b1101, 32'hFFFF0000, 32'h1};
    pv[3] = '{4'b0111, 32'h0, 32'h80000000, 4'b0111, 32'h0, 32'h80000000};

    rst_i = 1'b0;
    start_i = 1'b0;
    mcand_i = '0;
    mplier_i = '0;
    ex_aluctrl_i = '0;
    ex_src1_i = '0;
    ex_src2_i = '0;
    repeat (3) step();
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset done", 64'(done_o), 64'd0);
    check("reset hilo", {hi_o, lo_o}, 64'd0);
    check("reset stall", 64'(stall_o), 64'd0);
    rst_i = 1'b1;
    step();

    foreach (pv[i]) begin
      ex_aluctrl_i = pv[i].ctrl;
      ex_src1_i = pv[i].s1;
      ex_src2_i = pv[i].s2;
      #1;
      check("idle ctrl", 64'(alu_ctrl_o), 64'(pv[i].e_ctrl));
      check("idle src1", 64'(alu_src1_o), 64'(pv[i].e_s1));
      check("idle src2", 64'(alu_src2_o), 64'(pv[i].e_s2));
      check("idle stall", 64'(stall_o), 64'd0);
      check("idle busy", 64'(busy_o), 64'd0);
      step();
    end

    foreach (mv[i]) begin
      mul(mv[i].nm, mv[i].a, mv[i].b, mv[i].p, -1, -1);
      check({mv[i].nm, " done ctrl passthru"}, 64'(alu_ctrl_o),
            64'(ex_aluctrl_i));
      step();
      check({mv[i].nm, " done pulse"}, 64'(done_o), 64'd0);
      check({mv[i].nm, " hold"}, {hi_o, lo_o}, mv[i].p);
    end

    // start held high mid-run must not restart or double-complete
    mul("7x6 start held", 32'd7, 32'd6, 64'd42, 5, 20);
    step();
    check("7x6 single done", 64'(done_o), 64'd0);
    check("7x6 idle after", 64'(busy_o), 64'd0);

    // back-to-back: restart from the done cycle
    mul("b2b first", 32'd3, 32'd5, 64'd15, -1, -1);
    t0 = t_done;
    mul("b2b 0x10000^2", 32'h10000, 32'h10000, 64'h00000001_00000000,
        -1, -1);
    check("b2b done spacing", 64'(t_done - t0), 64'd33);
    step();

    // reset mid-operation
    mcand_i = 32'hFFFF;
    mplier_i = 32'hFFFF;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (10) step();
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    check("rst mid busy", 64'(busy_o), 64'd0);
    check("rst mid hilo", {hi_o, lo_o}, 64'd0);
    check("rst mid done", 64'(done_o), 64'd0);
    check("rst mid stall", 64'(stall_o), 64'd0);
    dn = 0;
    repeat (40) begin
      step();
      if (done_o) dn++;
    end
    check("rst mid no done", 64'(dn), 64'd0);
    mul("2x2 after rst", 32'd2, 32'd2, 64'd4, -1, -1);
    step();

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = ra >> $urandom_range(31, 1);
      if (i % 4 == 2) rb = rb | 32'h80000000;
      mul("random", ra, rb, 64'(ra) * 64'(rb), -1, -1);
      if (i % 2 == 0) step();
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
